// File: rtl/wps_gbx_pkg.sv
// State encoding and sizing helpers shared by the source gearbox top and its core.
package wps_gbx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        END   = 2'd3
    } gbx_state_e;

    // Worst-case buffer occupancy: a full beat landing on OUT_W-1 leftover bits.
    function automatic int gbx_buf_w(input int in_w, input int out_w);
        return in_w + out_w - 1;
    endfunction

    function automatic int gbx_cnt_w(input int max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/wps_gbx_core.sv
// LSB-first residual gearbox: appends IN_W beats above the fill level and pops OUT_W words from bit 0.
module wps_gbx_core
    import wps_gbx_pkg::*;
#(
    parameter int IN_W   = 256,
    parameter int OUT_W  = 24,
    parameter int BUF_W  = gbx_buf_w(IN_W, OUT_W),
    parameter int FILL_W = gbx_cnt_w(BUF_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              push,
    input  logic [IN_W-1:0]   push_data,
    input  logic              pop,
    output logic [FILL_W-1:0] cnt,
    output logic [OUT_W-1:0]  out_data
);

    logic [BUF_W-1:0]  gbuf_q;
    logic [FILL_W-1:0] cnt_q;

    // Bits at and above cnt_q are always zero, so an append is a plain OR
    // and the low OUT_W bits double as the zero-padded tail word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gbuf_q <= '0;
            cnt_q  <= '0;
        end else if (clr) begin
            gbuf_q <= '0;
            cnt_q  <= '0;
        end else if (push) begin
            gbuf_q <= gbuf_q | (BUF_W'(push_data) << cnt_q);
            cnt_q  <= cnt_q + FILL_W'(IN_W);
        end else if (pop) begin
            gbuf_q <= gbuf_q >> OUT_W;
            cnt_q  <= cnt_q - FILL_W'(OUT_W);
        end
    end

    assign cnt      = cnt_q;
    assign out_data = gbuf_q[OUT_W-1:0];

endmodule

// File: rtl/wps_src_gearbox.sv
// N-source read mux with beat counter and job FSM driving the IN_W->OUT_W gearbox core.
// Build option WPS_GBX_TAIL_FLUSH_EN: emit a non-zero job residual as one zero-padded final word.
module wps_src_gearbox
    import wps_gbx_pkg::*;
#(
    parameter int N_SRC = 2,
    parameter int IN_W  = 256,
    parameter int OUT_W = 24,
    parameter int SEL_W = 1,
    parameter int CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [SEL_W-1:0]      src_sel,
    input  logic [CNT_W-1:0]      beat_num,
    output logic                  busy,
    output logic                  done,
    output logic                  sel_err,
    input  logic [N_SRC*IN_W-1:0] src_data,
    input  logic [N_SRC-1:0]      src_valid,
    output logic [N_SRC-1:0]      src_ready,
    output logic [OUT_W-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int BUF_W  = gbx_buf_w(IN_W, OUT_W);
    localparam int FILL_W = gbx_cnt_w(BUF_W);
    localparam logic [FILL_W-1:0] OUT_W_F = FILL_W'(OUT_W);

    gbx_state_e        state_q, state_d;
    logic [SEL_W-1:0]  sel_q;
    logic [CNT_W-1:0]  beats_left_q;
    logic              zero_done_q;
    logic              sel_err_q;

    logic [FILL_W-1:0] cnt;
    logic [IN_W-1:0]   mux_data;
    logic              mux_valid;
    logic              word_ready;
    logic              ready_en;
    logic              in_fire;
    logic              pop;
    logic              clr;
    logic              start_take;
    logic              sel_ok;

    assign start_take = start && !abort && (state_q == IDLE);
    assign sel_ok     = int'(src_sel) < N_SRC;

    always_comb begin
        mux_data  = '0;
        mux_valid = 1'b0;
        for (int s = 0; s < N_SRC; s++) begin
            if (int'(sel_q) == s) begin
                mux_data  = src_data[s*IN_W +: IN_W];
                mux_valid = src_valid[s];
            end
        end
    end

    assign word_ready = (cnt >= OUT_W_F);
    assign ready_en   = (state_q == RUN) && (beats_left_q != '0) && !word_ready;
    assign in_fire    = ready_en && mux_valid;

    always_comb begin
        src_ready = '0;
        for (int s = 0; s < N_SRC; s++) begin
            src_ready[s] = ready_en && (int'(sel_q) == s);
        end
    end

    assign out_valid = ((state_q == RUN) && word_ready) || (state_q == FLUSH);
    assign busy      = (state_q == RUN) || (state_q == FLUSH);
    assign done      = (state_q == END) || zero_done_q;
    assign sel_err   = sel_err_q;

    always_comb begin
        state_d = state_q;
        clr     = 1'b0;
        pop     = 1'b0;
        if (abort) begin
            state_d = IDLE;
            clr     = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && sel_ok && (beat_num != '0)) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    pop = out_valid && out_ready;
                    if ((beats_left_q == '0) && !word_ready) begin
`ifdef WPS_GBX_TAIL_FLUSH_EN
                        if (cnt != '0) begin
                            state_d = FLUSH;
                        end else begin
                            state_d = END;
                        end
`else
                        state_d = END;
`endif
                    end
                end
                FLUSH: begin
                    if (out_ready) begin
                        clr     = 1'b1;
                        state_d = END;
                    end
                end
                END: begin
                    // Leftover residual (no tail flush) is discarded here.
                    clr     = 1'b1;
                    state_d = IDLE;
                end
                default: begin
                    clr     = 1'b1;
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sel_q        <= '0;
            beats_left_q <= '0;
            zero_done_q  <= 1'b0;
            sel_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            zero_done_q <= 1'b0;
            sel_err_q   <= 1'b0;
            if (abort) begin
                beats_left_q <= '0;
            end else if (start_take) begin
                sel_q        <= src_sel;
                beats_left_q <= beat_num;
                sel_err_q    <= !sel_ok;
                zero_done_q  <= sel_ok && (beat_num == '0);
            end else if (in_fire) begin
                beats_left_q <= beats_left_q - CNT_W'(1);
            end
        end
    end

    wps_gbx_core #(
        .IN_W   (IN_W),
        .OUT_W  (OUT_W),
        .BUF_W  (BUF_W),
        .FILL_W (FILL_W)
    ) u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .push      (in_fire),
        .push_data (mux_data),
        .pop       (pop),
        .cnt       (cnt),
        .out_data  (out_data)
    );

endmodule

// File: tb/tb_wps_src_gearbox.sv
// Self-checking bench for wps_src_gearbox with a bit-queue reference model of the repacking.
`timescale 1ns/1ps
module tb_wps_src_gearbox;

    localparam int N_SRC = 2;
    localparam int IN_W  = 256;
    localparam int OUT_W = 24;
    localparam int SEL_W = 2;
    localparam int CNT_W = 32;
    localparam int LIMIT = 4000;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  start;
    logic                  abort;
    logic [SEL_W-1:0]      src_sel;
    logic [CNT_W-1:0]      beat_num;
    logic                  busy;
    logic                  done;
    logic                  sel_err;
    logic [N_SRC*IN_W-1:0] src_data;
    logic [N_SRC-1:0]      src_valid;
    logic [N_SRC-1:0]      src_ready;
    logic [OUT_W-1:0]      out_data;
    logic                  out_valid;
    logic                  out_ready;

    int tests;
    int fails;

    logic [IN_W-1:0]  beat_q[$];
    logic [OUT_W-1:0] exp_q[$];
    logic [OUT_W-1:0] got_q[$];

    always #5 clk = ~clk;

    wps_src_gearbox #(
        .N_SRC (N_SRC),
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .SEL_W (SEL_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .src_sel   (src_sel),
        .beat_num  (beat_num),
        .busy      (busy),
        .done      (done),
        .sel_err   (sel_err),
        .src_data  (src_data),
        .src_valid (src_valid),
        .src_ready (src_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    function automatic logic [IN_W-1:0] rand_beat();
        logic [IN_W-1:0] v;
        for (int i = 0; i < IN_W/32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Reference: concatenate beats into one LSB-first bit stream and cut it into words.
    task automatic build_expected();
        bit bits[$];
        logic [OUT_W-1:0] w;
        exp_q = {};
        foreach (beat_q[b]) for (int i = 0; i < IN_W; i++) bits.push_back(beat_q[b][i]);
        while (bits.size() >= OUT_W) begin
            w = '0;
            for (int i = 0; i < OUT_W; i++) w[i] = bits.pop_front();
            exp_q.push_back(w);
        end
`ifdef WPS_GBX_TAIL_FLUSH_EN
        if (bits.size() > 0) begin
            int n;
            n = bits.size();
            w = '0;
            for (int i = 0; i < n; i++) w[i] = bits.pop_front();
            exp_q.push_back(w);
        end
`endif
    endtask

    task automatic run_job(input int sel, input int nb, input int vpct, input int rpct, input int stall_at);
        bit job_end;
        beat_q = {};
        for (int i = 0; i < nb; i++) beat_q.push_back(rand_beat());
        build_expected();
        got_q = {};
        @(negedge clk);
        src_valid = '0;
        start     = 1'b1;
        src_sel   = SEL_W'(sel);
        beat_num  = CNT_W'(nb);
        @(negedge clk);
        start = 1'b0;
        tests++;
        if (busy !== 1'b1) begin fails++; $display("FAIL job_busy: busy=%b expected 1", busy); end
        job_end = 1'b0;
        fork
            begin
                int idx;
                bit fired;
                idx = 0;
                fired = 1'b0;
                while (idx < nb && !job_end) begin
                    @(negedge clk);
                    if (fired) begin
                        src_valid = '0;
                        idx++;
                        fired = 1'b0;
                    end
                    if (idx < nb && src_valid == '0 && $urandom_range(99) < vpct) begin
                        src_valid[sel] = 1'b1;
                        src_data[sel*IN_W +: IN_W] = beat_q[idx];
                    end
                    fired = (src_valid[sel] === 1'b1) && (src_ready[sel] === 1'b1);
                end
            end
            begin
                int cyc;
                int stall;
                bit seen;
                logic pv, pr;
                logic [OUT_W-1:0] pd;
                logic [N_SRC-1:0] other;
                cyc = 0; stall = 0; seen = 1'b0; pv = 1'b0; pr = 1'b0; pd = '0;
                other = ~(N_SRC'(1) << sel);
                while (!seen && cyc < LIMIT) begin
                    @(negedge clk);
                    cyc++;
                    if (pv && !pr) begin
                        tests++;
                        if (out_valid !== 1'b1 || out_data !== pd) begin
                            fails++;
                            $display("FAIL hold_stable: valid=%b data=%h expected valid=1 data=%h", out_valid, out_data, pd);
                        end
                    end
                    tests++;
                    if ((src_ready & other) !== '0 || (out_valid === 1'b1 && src_ready !== '0)) begin
                        fails++;
                        $display("FAIL ready_excl: src_ready=%b out_valid=%b expected only selected ready and none while out_valid", src_ready, out_valid);
                    end
                    if (stall > 0) begin
                        out_ready = 1'b0;
                        stall--;
                    end else begin
                        out_ready = ($urandom_range(99) < rpct);
                    end
                    if (out_valid === 1'b1 && out_ready === 1'b1) begin
                        got_q.push_back(out_data);
                        if (got_q.size() == stall_at) stall = 5;
                    end
                    seen = (done === 1'b1);
                    pv = out_valid; pr = out_ready; pd = out_data;
                end
                tests++;
                if (!seen) begin fails++; $display("FAIL job_timeout: no done within %0d cycles, got %0d words", LIMIT, got_q.size()); end
                job_end = 1'b1;
            end
        join
        src_valid = '0;
        out_ready = 1'b0;
        tests++;
        if (got_q.size() != exp_q.size()) begin
            fails++;
            $display("FAIL word_count: got %0d expected %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            tests++;
            if (got_q[i] !== exp_q[i]) begin
                fails++;
                $display("FAIL word[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL job_end: busy=%b done=%b expected 0 0", busy, done);
        end
    endtask

    task automatic check_all_zero(input string tag);
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || sel_err !== 1'b0 || src_ready !== '0 ||
            out_valid !== 1'b0 || out_data !== '0) begin
            fails++;
            $display("FAIL %s: busy=%b done=%b sel_err=%b src_ready=%b out_valid=%b out_data=%h expected all 0",
                     tag, busy, done, sel_err, src_ready, out_valid, out_data);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset_held");
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("reset_release");
    endtask

    task automatic test_single_beat();
        logic [IN_W-1:0] a;
        int exp_n;
        run_job(0, 1, 100, 100, 0);
        a = beat_q[0];
        exp_n = 10;
`ifdef WPS_GBX_TAIL_FLUSH_EN
        exp_n = 11;
`endif
        tests++;
        if (got_q.size() != exp_n) begin fails++; $display("FAIL single_count: got %0d expected %0d", got_q.size(), exp_n); end
        for (int k = 0; k < 10 && k < got_q.size(); k++) begin
            tests++;
            if (got_q[k] !== a[k*24 +: 24]) begin fails++; $display("FAIL single_word[%0d]: got %h expected %h", k, got_q[k], a[k*24 +: 24]); end
        end
`ifdef WPS_GBX_TAIL_FLUSH_EN
        if (got_q.size() > 10) begin
            tests++;
            if (got_q[10] !== {8'h00, a[255:240]}) begin fails++; $display("FAIL single_tail: got %h expected %h", got_q[10], {8'h00, a[255:240]}); end
        end
`endif
    endtask

    task automatic test_two_beats();
        logic [IN_W-1:0] a, b;
        int exp_n;
        run_job(1, 2, 100, 100, 0);
        a = beat_q[0];
        b = beat_q[1];
        exp_n = 21;
`ifdef WPS_GBX_TAIL_FLUSH_EN
        exp_n = 22;
`endif
        tests++;
        if (got_q.size() != exp_n) begin fails++; $display("FAIL two_count: got %0d expected %0d", got_q.size(), exp_n); end
        if (got_q.size() > 10) begin
            tests++;
            if (got_q[10] !== {b[7:0], a[255:240]}) begin fails++; $display("FAIL two_straddle: got %h expected %h", got_q[10], {b[7:0], a[255:240]}); end
        end
`ifdef WPS_GBX_TAIL_FLUSH_EN
        if (got_q.size() > 21) begin
            tests++;
            if (got_q[21] !== {16'h0000, b[255:248]}) begin fails++; $display("FAIL two_tail: got %h expected %h", got_q[21], {16'h0000, b[255:248]}); end
        end
`endif
    endtask

    task automatic test_backpressure();
        run_job(0, 3, 80, 100, 4);
    endtask

    task automatic test_zero_and_sel_err();
        @(negedge clk);
        start = 1'b1; src_sel = 2'd0; beat_num = '0;
        @(negedge clk);
        start = 1'b0;
        tests++;
        if (done !== 1'b1 || busy !== 1'b0 || src_ready !== '0) begin
            fails++; $display("FAIL zero_done: done=%b busy=%b src_ready=%b expected 1 0 00", done, busy, src_ready);
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b0 || busy !== 1'b0 || src_ready !== '0) begin
            fails++; $display("FAIL zero_after: done=%b busy=%b src_ready=%b expected 0 0 00", done, busy, src_ready);
        end
        start = 1'b1; src_sel = 2'd2; beat_num = 32'd4;
        @(negedge clk);
        start = 1'b0;
        tests++;
        if (sel_err !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            fails++; $display("FAIL sel_err: sel_err=%b busy=%b done=%b expected 1 0 0", sel_err, busy, done);
        end
        @(negedge clk);
        tests++;
        if (sel_err !== 1'b0 || busy !== 1'b0 || src_ready !== '0) begin
            fails++; $display("FAIL sel_err_after: sel_err=%b busy=%b src_ready=%b expected 0 0 00", sel_err, busy, src_ready);
        end
    endtask

    task automatic test_abort();
        int n;
        int cyc;
        n = 0; cyc = 0;
        @(negedge clk);
        src_data[0 +: IN_W] = rand_beat();
        src_valid = 2'b01; out_ready = 1'b1;
        start = 1'b1; src_sel = 2'd0; beat_num = 32'd3;
        @(negedge clk);
        start = 1'b0;
        while (n < 4 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (out_valid === 1'b1) n++;
        end
        tests++;
        if (n < 4) begin fails++; $display("FAIL abort_words: saw %0d words expected 4", n); end
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        src_valid = '0;
        tests++;
        if (out_valid !== 1'b0 || src_ready !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            fails++; $display("FAIL abort_next: out_valid=%b src_ready=%b busy=%b done=%b expected all 0", out_valid, src_ready, busy, done);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            tests++;
            if (done !== 1'b0 || out_valid !== 1'b0) begin
                fails++; $display("FAIL abort_quiet: done=%b out_valid=%b expected 0 0", done, out_valid);
            end
        end
        out_ready = 1'b0;
        run_job(1, 2, 90, 90, 0);
    endtask

    task automatic test_async_reset();
        logic [IN_W-1:0] a;
        int cyc;
        a = rand_beat();
        cyc = 0;
        @(negedge clk);
        src_data[0 +: IN_W] = a;
        src_valid = 2'b01; out_ready = 1'b0;
        start = 1'b1; src_sel = 2'd0; beat_num = 32'd5;
        @(negedge clk);
        start = 1'b0;
        while (out_valid !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        tests++;
        if (out_valid !== 1'b1 || out_data !== a[23:0]) begin
            fails++; $display("FAIL areset_first: out_valid=%b out_data=%h expected 1 %h", out_valid, out_data, a[23:0]);
        end
        start = 1'b1; src_sel = 2'd2; beat_num = '0;
        @(negedge clk);
        start = 1'b0;
        tests++;
        if (sel_err !== 1'b0 || done !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b1) begin
            fails++; $display("FAIL start_busy: sel_err=%b done=%b busy=%b out_valid=%b expected 0 0 1 1", sel_err, done, busy, out_valid);
        end
        #2 rst_n = 1'b0;
        #1 check_all_zero("areset_immediate");
        @(negedge clk);
        src_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("areset_release");
        run_job(0, 2, 100, 100, 0);
    endtask

    task automatic test_random();
        for (int j = 0; j < 5; j++) begin
            run_job(int'($urandom_range(1)), int'($urandom_range(5, 1)),
                    int'($urandom_range(100, 40)), int'($urandom_range(100, 30)), 0);
        end
    endtask

    initial begin
        tests = 0; fails = 0;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; src_sel = '0; beat_num = '0;
        src_data = '0; src_valid = '0; out_ready = 1'b0;
        test_reset();
        test_single_beat();
        test_two_beats();
        test_backpressure();
        test_zero_and_sel_err();
        test_abort();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1);
    end

endmodule

// File: doc/wps_src_gearbox.md
Name: wps_src_gearbox

Overview:
- Parametrised successor to the fixed two-source (DDR3 / on-chip memory) read mux feeding the 256-to-24 interface.
- Selects one of N_SRC valid/ready read streams per job, counts IN_W-bit beats and repacks them into OUT_W-bit pixel words with an LSB-first residual gearbox.
- Single clock domain on the memory side. The output feeds the pingpong FIFO writer.

Parameters:
- N_SRC, 2, number of read sources (DDR3, on-chip, ...).
- IN_W, 256, source beat width in bits.
- OUT_W, 24, output word width in bits; must satisfy OUT_W <= IN_W.
- SEL_W, 1, width of src_sel; must satisfy 2**SEL_W >= N_SRC.
- CNT_W, 32, width of the beat counter.

Ports:
- clk  in  1  memory-side clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle job request; sampled only in IDLE.
- abort  in  1  synchronous job cancel.
- src_sel  in  SEL_W  source index, latched on start.
- beat_num  in  CNT_W  number of IN_W beats in the job, latched on start.
- busy  out  1  high while a job is active.
- done  out  1  one-cycle pulse at normal job end.
- sel_err  out  1  one-cycle pulse when src_sel >= N_SRC.
- src_data  in  N_SRC*IN_W  source s occupies bits [s*IN_W +: IN_W].
- src_valid  in  N_SRC  per-source beat valid.
- src_ready  out  N_SRC  per-source ready; only the selected bit can be high.
- out_data  out  OUT_W  repacked word.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accept.

Behaviour:
- Reset values: busy=0, done=0, sel_err=0, src_ready=0, out_valid=0, out_data=0. Fill count cnt=0, state IDLE.
- Buffer: BUF_W = IN_W+OUT_W-1 bits. cnt ranges 0..BUF_W. Bit 0 is the oldest bit.
- Push: in_fire = src_valid[sel] & src_ready[sel].
  - src_ready[sel] = (state==RUN) & (beats_left!=0) & (cnt<OUT_W).
  - The incoming beat is written at bit position cnt; cnt += IN_W.
- Pop: out_valid = (cnt>=OUT_W) in RUN or FLUSH.
  - out_data = buf[OUT_W-1:0], registered.
  - On out_valid & out_ready the buffer shifts right by OUT_W and cnt -= OUT_W.
- Push and pop are mutually exclusive in one cycle, because push requires cnt<OUT_W and pop requires cnt>=OUT_W. cnt can never overflow.
- While out_valid=1 and out_ready=0, out_data is held stable.
- States:
  - IDLE: on start (with abort low), latch sel and beat_num; set beats_left=beat_num.
    - If src_sel>=N_SRC: pulse sel_err and stay in IDLE.
    - Else if beat_num==0: pulse done next cycle and stay in IDLE.
    - Else go to RUN with busy=1.
  - RUN: each in_fire decrements beats_left. When beats_left==0 and cnt<OUT_W:
    - go to FLUSH if the optional feature is enabled and cnt>0;
    - otherwise go to END.
  - FLUSH: present one word {zero pad, residual cnt bits}. On accept, set cnt=0 and go to END.
  - END: pulse done for one cycle, set busy=0, return to IDLE.
- Timing: first out_valid appears 1 cycle after the first in_fire. Throughput is one push cycle per floor-based group of pops (256/24 gives 10 or 11 words per beat).
- start while busy is ignored and produces no error.
- abort in any state:
  - next cycle: state=IDLE, cnt=0, beats_left=0, out_valid=0, src_ready=0;
  - no done pulse.
  - abort has priority over a simultaneous start.
- Residual bits are discarded at END when the optional feature is absent. cnt is cleared on entering IDLE.

Optional Feature:
- Macro: WPS_GBX_TAIL_FLUSH_EN.
- Defined: a non-zero residual at job end is emitted as one zero-padded final word (FLUSH state).
- Undefined: there is no FLUSH state; the residual is dropped and the job ends once cnt<OUT_W.

Decomposition:
- Package wps_gbx_pkg holds:
  - the state encoding constants IDLE/RUN/FLUSH/END;
  - the BUF_W and count-width helper functions (clog2).
- One sub-module, wps_gbx_core, holds the buffer, cnt and the shift/append/pop datapath.
- The top-level module keeps the FSM, the source mux and the beat counter.

Test Plan:
All cases use IN_W=256, OUT_W=24, N_SRC=2.
- Single beat, src_sel=0, beat_num=1, out_ready=1 → 10 words equal to in[23:0]..in[239:216].
  - With flush: an 11th word {8'h00, in[255:240]}.
  - Then done pulse, busy=0, src_ready[1]=0 throughout.
- Two beats on src 1, data patterns A and B → 21 words.
  - Word 10 = {B[7:0], A[255:240]}.
  - Residual 8 bits, flushed as {16'h0, B[255:248]} only when the macro is defined.
- out_ready held low 5 cycles mid-job → out_data stable, src_ready=0, no loss; full sequence matches the reference model.
- beat_num=0 → done one cycle after start, no src_ready asserted. src_sel=2 → sel_err pulse, busy stays 0.
- abort after 4 output words → next cycle out_valid=0, cnt=0, no done pulse. A new start then runs a clean job.
- Async reset mid-RUN → all outputs 0 immediately. start asserted while busy is ignored.
